// File: rtl/board_ctrl_if.sv
// Button, status and pixel read-port bundle between the Gomoku UI and board_ctrl.
// The UI side uses the master modport; board_ctrl uses the slave modport.
interface board_ctrl_if #(
   parameter int BOARD_DIM = 6
);
   localparam int CW = $clog2(BOARD_DIM);
   localparam int IW = $clog2(BOARD_DIM * BOARD_DIM);

   logic          btn_up;
   logic          btn_down;
   logic          btn_left;
   logic          btn_right;
   logic          btn_place;
   logic [IW-1:0] rd_idx;
   logic [1:0]    rd_cell;
   logic [CW-1:0] cursor_x;
   logic [CW-1:0] cursor_y;
   logic          turn;
   logic          busy;
   logic          place_ok;
   logic          place_rej;
   logic          game_over;
   logic [1:0]    winner;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_place, rd_idx,
      input  rd_cell, cursor_x, cursor_y, turn, busy, place_ok, place_rej,
             game_over, winner
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_place, rd_idx,
      output rd_cell, cursor_x, cursor_y, turn, busy, place_ok, place_rej,
             game_over, winner
   );
endinterface

// File: rtl/board_ctrl.sv
// Gomoku game-state engine: N x N board, cursor, turn and a one-cell-per-cycle win scan.
// Define BOARD_CURSOR_WRAP_EN to make the cursor wrap at the board edges instead of saturating.
module board_ctrl #(
   parameter int BOARD_DIM = 6,
   parameter int WIN_LEN   = 5
) (
   input  logic        clk,
   input  logic        rst,
   board_ctrl_if.slave bus
);
   localparam int CW = $clog2(BOARD_DIM);
   localparam int IW = $clog2(BOARD_DIM * BOARD_DIM);
   localparam int NN = BOARD_DIM * BOARD_DIM;
   localparam int PW = CW + 2;
   localparam int MW = $clog2(NN + 1);
   localparam int KW = $clog2(WIN_LEN + 1);
   localparam logic [CW-1:0] MAX_C = CW'(BOARD_DIM - 1);
   localparam logic [CW-1:0] MID_C = CW'(BOARD_DIM / 2);
`ifdef BOARD_CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;
   typedef enum logic [1:0] {DIR_E, DIR_S, DIR_SE, DIR_NE} dir_t;
   typedef logic signed [PW-1:0] pos_t;

   localparam pos_t MAX_P = pos_t'(BOARD_DIM - 1);

   state_t        state;
   dir_t          dir;
   logic          side;
   logic [1:0]    board [NN];
   logic [CW-1:0] org_x, org_y, cur_x, cur_y, nxt_x, nxt_y;
   logic [1:0]    color, winner;
   pos_t          pos_x, pos_y, org_sx, org_sy;
   logic [KW-1:0] count;
   logic [MW-1:0] moves;
   logic          turn, busy, place_ok, place_rej, game_over;
   logic [IW-1:0] cur_idx, cand_idx;
   logic [1:0]    cand_cell, stone;
   logic          in_bounds, match, hit_win;
   dir_t          dir_nx;

   // Unit step of a scan direction; side=1 walks the opposite way.
   function automatic pos_t step_x(input dir_t d, input logic neg);
      pos_t s;
      s = (d == DIR_S) ? pos_t'(0) : pos_t'(1);
      return neg ? -s : s;
   endfunction

   function automatic pos_t step_y(input dir_t d, input logic neg);
      pos_t s;
      case (d)
         DIR_E:   s = pos_t'(0);
         DIR_NE:  s = pos_t'(-1);
         default: s = pos_t'(1);
      endcase
      return neg ? -s : s;
   endfunction

   assign org_sx    = pos_t'({2'b00, org_x});
   assign org_sy    = pos_t'({2'b00, org_y});
   assign dir_nx    = dir_t'(dir + 2'd1);
   assign stone     = {turn, ~turn};
   assign cur_idx   = IW'(cur_y) * IW'(BOARD_DIM) + IW'(cur_x);
   assign in_bounds = (pos_x >= pos_t'(0)) && (pos_x <= MAX_P) &&
                      (pos_y >= pos_t'(0)) && (pos_y <= MAX_P);
   assign cand_idx  = IW'(pos_y[CW-1:0]) * IW'(BOARD_DIM) + IW'(pos_x[CW-1:0]);
   assign cand_cell = in_bounds ? board[cand_idx] : 2'b00;
   assign match     = in_bounds && (cand_cell == color);
   assign hit_win   = match && (count == KW'(WIN_LEN - 1));

   assign bus.rd_cell   = (int'(bus.rd_idx) < NN) ? board[bus.rd_idx] : 2'b00;
   assign bus.cursor_x  = cur_x;
   assign bus.cursor_y  = cur_y;
   assign bus.turn      = turn;
   assign bus.busy      = busy;
   assign bus.place_ok  = place_ok;
   assign bus.place_rej = place_rej;
   assign bus.game_over = game_over;
   assign bus.winner    = winner;

   // NOTE: next-cursor values get a default before any condition so this block cannot infer a latch.
   always_comb begin
      nxt_x = cur_x;
      nxt_y = cur_y;
      if (bus.btn_right && !bus.btn_left)
         nxt_x = (cur_x == MAX_C) ? (WRAP ? '0 : MAX_C) : cur_x + 1'b1;
      else if (bus.btn_left && !bus.btn_right)
         nxt_x = (cur_x == '0) ? (WRAP ? MAX_C : '0) : cur_x - 1'b1;
      if (bus.btn_down && !bus.btn_up)
         nxt_y = (cur_y == MAX_C) ? (WRAP ? '0 : MAX_C) : cur_y + 1'b1;
      else if (bus.btn_up && !bus.btn_down)
         nxt_y = (cur_y == '0) ? (WRAP ? MAX_C : '0) : cur_y - 1'b1;
   end

   // NOTE: non-blocking assignments here, so every decision below sees pre-edge register values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_x <= MID_C;
         cur_y <= MID_C;
      end else begin
         cur_x <= nxt_x;
         cur_y <= nxt_y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the board is a register array, not RAM: rst and restart both clear every cell at once.
         for (int i = 0; i < NN; i++) board[i] <= 2'b00;
         state     <= IDLE;
         dir       <= DIR_E;
         side      <= 1'b0;
         org_x     <= '0;
         org_y     <= '0;
         color     <= 2'b00;
         pos_x     <= pos_t'(0);
         pos_y     <= pos_t'(0);
         count     <= '0;
         moves     <= '0;
         turn      <= 1'b0;
         busy      <= 1'b0;
         place_ok  <= 1'b0;
         place_rej <= 1'b0;
         game_over <= 1'b0;
         winner    <= 2'b00;
      end else begin
         place_ok  <= 1'b0;
         place_rej <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.btn_place) begin
                  if (board[cur_idx] == 2'b00) begin
                     board[cur_idx] <= stone;
                     org_x    <= cur_x;
                     org_y    <= cur_y;
                     color    <= stone;
                     moves    <= moves + 1'b1;
                     count    <= KW'(1);
                     dir      <= DIR_E;
                     side     <= 1'b0;
                     pos_x    <= pos_t'({2'b00, cur_x}) + pos_t'(1);
                     pos_y    <= pos_t'({2'b00, cur_y});
                     busy     <= 1'b1;
                     place_ok <= 1'b1;
                     state    <= SCAN;
                  end else begin
                     place_rej <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (bus.btn_place) place_rej <= 1'b1;
               if (hit_win) begin
                  busy      <= 1'b0;
                  game_over <= 1'b1;
                  winner    <= color;
                  state     <= OVER;
               end else if (match) begin
                  count <= count + 1'b1;
                  pos_x <= pos_x + step_x(dir, side);
                  pos_y <= pos_y + step_y(dir, side);
               end else if (!side) begin
                  side  <= 1'b1;
                  pos_x <= org_sx + step_x(dir, 1'b1);
                  pos_y <= org_sy + step_y(dir, 1'b1);
               end else if (dir == DIR_NE) begin
                  busy <= 1'b0;
                  if (moves == MW'(NN)) begin
                     game_over <= 1'b1;
                     winner    <= 2'b11;
                     state     <= OVER;
                  end else begin
                     turn  <= ~turn;
                     state <= IDLE;
                  end
               end else begin
                  dir   <= dir_nx;
                  side  <= 1'b0;
                  count <= KW'(1);
                  pos_x <= org_sx + step_x(dir_nx, 1'b0);
                  pos_y <= org_sy + step_y(dir_nx, 1'b0);
               end
            end
            OVER: begin
               if (bus.btn_place) begin
                  for (int i = 0; i < NN; i++) board[i] <= 2'b00;
                  turn      <= 1'b0;
                  winner    <= 2'b00;
                  game_over <= 1'b0;
                  moves     <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/board_ctrl.md
# board_ctrl

Parametrised game-state engine for the Gomoku UI. It owns an N×N board of 2-bit cells, the cursor position and the turn, and accepts one-pulse button inputs. After each placement it runs a sequential win scan for WIN_LEN in a row. A combinational read port feeds the VGA pixel generator, replacing the fixed, preloaded 36-cell board image.

## Interface
- BOARD_DIM, 6: board edge length N, 3..16.
- WIN_LEN, 5: stones in a row needed to win, 3..BOARD_DIM.
- Derived: CW = $clog2(BOARD_DIM), IW = $clog2(BOARD_DIM*BOARD_DIM).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_up / btn_down / btn_left / btn_right  in  1 each  one-cycle move pulses, already debounced upstream.
- btn_place  in  1  one-cycle place / restart pulse.
- rd_idx  in  IW  pixel-generator cell index, row-major: y*BOARD_DIM + x.
- rd_cell  out  2  cell at rd_idx. Encoding: 00 empty, 01 black, 10 white. Value 11 is never stored.
- cursor_x, cursor_y  out  CW  cursor column and row.
- turn  out  1  side to move: 0 black, 1 white.
- busy  out  1  win scan in progress.
- place_ok, place_rej  out  1  one-cycle placement result pulses.
- game_over  out  1  game finished.
- winner  out  2  00 none, 01 black, 10 white, 11 draw.

## Operation
- States: IDLE, SCAN, OVER.
- IDLE + btn_place with target cell empty:
  - write stone (turn+1) at the cursor;
  - latch origin and color, increment the move counter;
  - set count=1, dir=E, side=+; go to SCAN.
- IDLE + btn_place with target cell occupied: place_rej; no other change.
- SCAN, one candidate cell per cycle:
  - Candidate = origin + k·step(dir, side).
  - In bounds and same color: count++, k++.
  - Out of bounds or mismatched color: if side=+, switch to side=−, k=1; otherwise advance dir and reset count=1, side=+, k=1.
- Scan directions, in order: E (1,0), S (0,1), SE (1,1), NE (1,−1).
- count reaching WIN_LEN: go to OVER with winner=color. The scan stops at once.
- All four directions exhausted with no win:
  - move counter = N²: go to OVER, winner=11;
  - otherwise toggle turn and return to IDLE.
- btn_place during SCAN: place_rej; nothing else changes.
- OVER + btn_place, restart:
  - clear every cell in parallel, in one cycle;
  - turn=0, winner=00, game_over=0, move counter=0;
  - cursor unchanged; go to IDLE. No place_ok or place_rej pulse.
- Cursor moves are accepted in every state.
  - Opposite pulses on the same axis in the same cycle cancel.
  - Placement uses the pre-move cursor when a move and btn_place coincide.
- rd_idx ≥ N² returns 00.
- rst, including mid-SCAN:
  - all cells 00; cursor (BOARD_DIM/2, BOARD_DIM/2); turn 0;
  - busy, place_ok, place_rej, game_over 0; winner 00; move counter 0; state IDLE.

## Timing
- Button inputs are sampled on the rising edge of clk.
- On the accepting edge: cell write, place_ok, busy=1 and SCAN entry all take effect.
- Written stone is visible on rd_cell from the next cycle.
- rd_cell is purely combinational from rd_idx, with zero latency.
- Scan length: at most 4·(2·WIN_LEN) cycles; minimum 8 cycles, for an isolated stone.
- busy falls, and turn toggles or game_over rises, on the same edge that leaves SCAN.
- place_rej is registered: asserted for one cycle, the cycle after the offending btn_place.
- Cursor registers update on the sampling edge.

## Configuration
- BOARD_CURSOR_WRAP_EN defined: the cursor wraps around at each edge.
  - Example: left at x=0 gives x=BOARD_DIM−1; down at y=BOARD_DIM−1 gives y=0.
- BOARD_CURSOR_WRAP_EN undefined: the cursor saturates at 0 and BOARD_DIM−1.

## Test plan
- Reset, then btn_place (default 6/5) → next cycle place_ok=1, rd_cell(21)=01, busy=1. After ≤40 cycles: busy=0, turn=1.
- Place on occupied cell 21 → place_rej one cycle; cell stays 01; turn unchanged.
- Black at (0,0),(1,0),(3,0),(4,0), white stones elsewhere, final black placed at (2,0) → game_over=1, winner=01 within 40 cycles. A further btn_place clears all cells to 00 and sets turn=0.
- Diagonal NE win with black at (0,4),(1,3),(2,2),(3,1),(4,0) → winner=01. Same line with one white stone inserted → no win.
- BOARD_DIM=3, WIN_LEN=3, fill all 9 cells with no line (B W B / B W W / W B B) → winner=11, game_over=1.
- Cursor at x=0, btn_left → x=5 with wrap, x=0 without. btn_up and btn_down in the same cycle → y unchanged. rst asserted mid-SCAN → all outputs at reset values next cycle.
